// File: rtl/pixel_pkg.sv
// Shared screen geometry and colour codes for the pixel-stream producer and readers.
package pixel_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned BASE_Y   = 84;
    localparam int unsigned RUN_MAX  = 79;
    localparam int unsigned PAIRS    = (SCREEN_W - 2) / 2;

    localparam logic [2:0] C_BG  = 3'b011;
    localparam logic [2:0] C_RUN = 3'b100;
    localparam logic [2:0] C_OBS = 3'b110;

    typedef enum logic {
        ST_SYNC,
        ST_RUN
    } scan_state_e;

    function automatic logic colour_known(input logic [2:0] c);
        return (c == C_BG) || (c == C_RUN) || (c == C_OBS);
    endfunction

endpackage

// File: rtl/pixel_scan_decoder_if.sv
// Pixel-write bus shared by the display serializer, the VGA adapter and its readers.
interface pixel_scan_decoder_if;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output x, output y, output colour, output plot);
    modport slave  (input  x, input  y, input  colour, input  plot);
endinterface

// File: rtl/pixel_classify.sv
// Combinational decode of one pixel write: column class, pair index, baseline offset and legality.
module pixel_classify #(
    parameter int unsigned RUN_MAX = pixel_pkg::RUN_MAX,
    parameter int unsigned PAIRS   = pixel_pkg::PAIRS
) (
    input  logic [7:0] i_x,
    input  logic [6:0] i_y,
    input  logic [2:0] i_colour,
    output logic       o_is_runner_col,
    output logic       o_is_obs_col,
    output logic [6:0] o_pair,
    output logic [6:0] o_off,
    output logic       o_off_ok,
    output logic       o_colour_ok
);
    import pixel_pkg::*;

    logic [7:0] w_off8;

    // 8-bit subtraction: bit 7 set means the row lies below the baseline
    assign w_off8          = 8'(BASE_Y) - {1'b0, i_y};
    assign o_off           = w_off8[6:0];
    assign o_is_runner_col = (i_x <= 8'd1);
    assign o_is_obs_col    = (i_x >= 8'd2) && (i_x <= 8'(2 * PAIRS + 1));
    assign o_pair          = 7'((i_x - 8'd2) >> 1);
    assign o_colour_ok     = colour_known(i_colour);

    always_comb begin
        o_off_ok = 1'b0;
        if (!w_off8[7]) begin
            if (o_is_runner_col)
                o_off_ok = (w_off8 <= 8'(RUN_MAX));
            else if (o_is_obs_col)
                o_off_ok = (w_off8 <= 8'd3);
        end
    end

endmodule

// File: rtl/pixel_scan_decoder.sv
// Rebuilds runner height, obstacle heights and collision from the pixel-write stream, one frame at a time.
module pixel_scan_decoder #(
    parameter int unsigned RUN_MAX = pixel_pkg::RUN_MAX,
    parameter int unsigned PAIRS   = pixel_pkg::PAIRS
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_scan_decoder_if.slave  pix,
    output logic [6:0]           runner_height,
    output logic                 runner_valid,
    output logic [2*PAIRS-1:0]   obst_map,
    output logic                 collision,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic                 proto_err
);
    import pixel_pkg::*;

    scan_state_e r_state, w_state_next;

    logic [7:0]         r_prev_x;
    logic [6:0]         r_run_min;
    logic               r_run_seen;
    logic [2*PAIRS-1:0] r_h;

    logic [6:0]         r_runner_height;
    logic               r_runner_valid;
    logic [2*PAIRS-1:0] r_obst_map;
    logic               r_collision;
    logic               r_frame_done;
    logic [15:0]        r_frame_count;
    logic               r_proto_err;

    logic       w_is_runner_col, w_is_obs_col, w_off_ok, w_colour_ok;
    logic [6:0] w_pair, w_off;
    logic [7:0] w_bit_idx;

    logic w_sync_hit, w_boundary;
    logic w_start_frame, w_process, w_publish;
    logic w_err, w_acc_run, w_acc_obs, w_collision;

    logic [6:0]         w_run_min_nx;
    logic               w_run_seen_nx;
    logic [2*PAIRS-1:0] w_h_nx;

    pixel_classify #(
        .RUN_MAX (RUN_MAX),
        .PAIRS   (PAIRS)
    ) u_classify (
        .i_x             (pix.x),
        .i_y             (pix.y),
        .i_colour        (pix.colour),
        .o_is_runner_col (w_is_runner_col),
        .o_is_obs_col    (w_is_obs_col),
        .o_pair          (w_pair),
        .o_off           (w_off),
        .o_off_ok        (w_off_ok),
        .o_colour_ok     (w_colour_ok)
    );

    assign w_sync_hit = pix.plot && (pix.x == 8'd0) && (pix.y == 7'(BASE_Y));
    assign w_boundary = pix.plot && (pix.x == 8'd0) && (r_prev_x >= 8'd2);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_SYNC;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_SYNC: if (w_sync_hit) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_SYNC;
        endcase
    end

    // The sync pixel opens the first frame exactly like a boundary pixel, minus publishing
    always_comb begin
        w_start_frame = 1'b0;
        w_process     = 1'b0;
        w_publish     = 1'b0;
        unique case (r_state)
            ST_SYNC: begin
                w_start_frame = w_sync_hit;
                w_process     = w_sync_hit;
            end
            ST_RUN: begin
                w_start_frame = w_boundary;
                w_publish     = w_boundary;
                w_process     = pix.plot;
            end
            default: ;
        endcase
    end

    assign w_err     = w_process && !(w_off_ok && w_colour_ok);
    assign w_acc_run = w_process && !w_err && w_is_runner_col && !pix.x[0]
                       && (pix.colour == C_RUN) && (w_off != 7'd0);
    assign w_acc_obs = w_process && !w_err && w_is_obs_col
                       && (pix.colour == C_OBS) && (w_off != 7'd0);
    assign w_bit_idx = {w_pair, 1'b0};

    always_comb begin
        w_run_min_nx  = w_start_frame ? 7'h7F : r_run_min;
        w_run_seen_nx = w_start_frame ? 1'b0  : r_run_seen;
        w_h_nx        = w_start_frame ? '0    : r_h;
        if (w_acc_run) begin
            w_run_seen_nx = 1'b1;
            if (w_off < w_run_min_nx)
                w_run_min_nx = w_off;
        end
        if (w_acc_obs && (w_off[1:0] > w_h_nx[w_bit_idx +: 2]))
            w_h_nx[w_bit_idx +: 2] = w_off[1:0];
    end

    assign w_collision = r_run_seen && (r_h[1:0] != 2'b00)
                         && (r_run_min <= {5'b0, r_h[1:0]});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_x        <= '0;
            r_run_min       <= 7'h7F;
            r_run_seen      <= 1'b0;
            r_h             <= '0;
            r_runner_height <= '0;
            r_runner_valid  <= 1'b0;
            r_obst_map      <= '0;
            r_collision     <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_count   <= '0;
            r_proto_err     <= 1'b0;
        end else begin
            r_frame_done <= w_publish;
            if (pix.plot)
                r_prev_x <= pix.x;
            if (w_process) begin
                r_run_min  <= w_run_min_nx;
                r_run_seen <= w_run_seen_nx;
                r_h        <= w_h_nx;
            end
            if (w_err)
                r_proto_err <= 1'b1;
            if (w_publish) begin
                r_runner_height <= r_run_seen ? r_run_min : '0;
                r_runner_valid  <= r_run_seen;
                r_obst_map      <= r_h;
                r_collision     <= w_collision;
                r_frame_count   <= r_frame_count + 16'd1;
            end
        end
    end

    assign runner_height = r_runner_height;
    assign runner_valid  = r_runner_valid;
    assign obst_map      = r_obst_map;
    assign collision     = r_collision;
    assign frame_done    = r_frame_done;
    assign frame_count   = r_frame_count;
    assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_pixel_scan_decoder.sv
// Scoreboard bench: a frame-level reference model queues expected outputs, a monitor checks every cycle.
module tb_pixel_scan_decoder;

    localparam int NP   = 79;
    localparam int BY   = 84;
    localparam int XMAX = 2 * NP + 1;
    localparam logic [2:0] BG  = 3'b011;
    localparam logic [2:0] RUN = 3'b100;
    localparam logic [2:0] OBS = 3'b110;

    typedef struct packed {
        int           cyc;
        logic [6:0]   height;
        logic         valid;
        logic [2*NP-1:0] map;
        logic         coll;
        logic [15:0]  count;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [6:0]      runner_height;
    logic            runner_valid;
    logic [2*NP-1:0] obst_map;
    logic            collision;
    logic            frame_done;
    logic [15:0]     frame_count;
    logic            proto_err;

    pixel_scan_decoder_if pif ();

    pixel_scan_decoder #(
        .RUN_MAX (79),
        .PAIRS   (NP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pix           (pif.slave),
        .runner_height (runner_height),
        .runner_valid  (runner_valid),
        .obst_map      (obst_map),
        .collision     (collision),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 0;
    exp_t q[$];
    exp_t last;
    logic exp_err_vis;

    // Reference model state: what a reader of the pixel stream knows about the current frame
    bit          m_synced;
    int          m_prev_x;
    bit          m_seen;
    int          m_min;
    int          m_h[NP];
    bit          m_err;
    logic [15:0] m_count;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_frame();
        m_seen = 0;
        m_min  = 1000;
        for (int k = 0; k < NP; k++) m_h[k] = 0;
    endtask

    task automatic model_reset();
        m_synced = 0; m_prev_x = 0; m_err = 0; m_count = '0;
        clear_frame();
    endtask

    task automatic model_pixel(input int x, input int off, input logic [2:0] c);
        bit bad;
        bad = !(c == BG || c == RUN || c == OBS);
        if (x > XMAX) bad = 1;
        else if (x <= 1) begin
            if (off < 0 || off > 79) bad = 1;
        end else if (off < 0 || off > 3) bad = 1;
        if (bad) m_err = 1;
        else if (x == 0 && c == RUN && off >= 1) begin
            m_seen = 1;
            if (off < m_min) m_min = off;
        end else if (x >= 2 && c == OBS && off >= 1) begin
            if (off > m_h[(x - 2) / 2]) m_h[(x - 2) / 2] = off;
        end
    endtask

    function automatic exp_t frame_result();
        exp_t e;
        e = '0;
        e.valid  = m_seen;
        e.height = m_seen ? 7'(m_min) : 7'd0;
        e.coll   = m_seen && (m_h[0] != 0) && (m_min <= m_h[0]);
        for (int k = 0; k < NP; k++) e.map[2*k +: 2] = 2'(m_h[k]);
        return e;
    endfunction

    task automatic px(input int x, input int y, input logic [2:0] c);
        exp_t e;
        bit   pub;
        int   off;
        off = BY - y;
        pub = 0;
        e   = '0;
        if (!m_synced) begin
            if (x == 0 && y == BY) begin
                m_synced = 1;
                clear_frame();
                model_pixel(x, off, c);
            end
        end else begin
            if (x == 0 && m_prev_x >= 2) begin
                pub = 1;
                e = frame_result();
                m_count = m_count + 16'd1;
                e.count = m_count;
                clear_frame();
            end
            model_pixel(x, off, c);
        end
        m_prev_x = x;
        if (pub) begin
            e.err = m_err;
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        pif.x = 8'(x); pif.y = 7'(y); pif.colour = c; pif.plot = 1'b1;
        @(posedge clk); #1;
        pif.plot = 1'b0;
        exp_err_vis = m_err;
    endtask

    task automatic idle(input int n);
        pif.plot = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        last = '0;
        exp_err_vis = 1'b0;
    endtask

    function automatic logic [2:0] rcol();
        case ($urandom_range(0, 2))
            0: return BG;
            1: return RUN;
            default: return OBS;
        endcase
    endfunction

    task automatic rand_frame(input bit allow_err);
        int n, x, y;
        logic [2:0] c;
        px(0, BY, BG);
        n = int'($urandom_range(0, 5));
        for (int i = 0; i < n; i++) begin
            x = ($urandom_range(0, 3) == 0) ? 1 : 0;
            y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(80, 84)) : int'($urandom_range(5, 84));
            c = ($urandom_range(0, 1) == 1) ? RUN : rcol();
            if (allow_err && $urandom_range(0, 9) == 0) y = int'($urandom_range(0, 127));
            px(x, y, c);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        n = int'($urandom_range(1, 6));
        for (int i = 0; i < n; i++) begin
            x = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 9)) : int'($urandom_range(2, XMAX));
            y = int'($urandom_range(81, 84));
            c = ($urandom_range(0, 1) == 1) ? OBS : rcol();
            if (allow_err && $urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: x = int'($urandom_range(XMAX + 1, 255));
                    1: y = int'($urandom_range(60, 127));
                    default: c = 3'($urandom_range(0, 7));
                endcase
            end
            px(x, y, c);
        end
    endtask

    // Monitor: frame_done must appear exactly when queued; otherwise outputs must hold
    always @(negedge clk) begin
        if (mon_en) begin
            bit   exp_fd;
            exp_t e;
            exp_fd = (q.size() > 0) && (q[0].cyc == cyc);
            chk("frame_done", 192'(frame_done), 192'(exp_fd));
            if (exp_fd) begin
                e = q.pop_front();
                if (frame_done) begin
                    chk("runner_height", 192'(runner_height), 192'(e.height));
                    chk("runner_valid",  192'(runner_valid),  192'(e.valid));
                    chk("obst_map",      192'(obst_map),      192'(e.map));
                    chk("collision",     192'(collision),     192'(e.coll));
                    chk("frame_count",   192'(frame_count),   192'(e.count));
                end
                last = e;
            end else begin
                chk("hold", 192'({runner_height, runner_valid, collision, frame_count, obst_map}),
                    192'({last.height, last.valid, last.coll, last.count, last.map}));
            end
            chk("proto_err", 192'(proto_err), 192'(exp_err_vis));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pif.x = '0; pif.y = '0; pif.colour = '0; pif.plot = 1'b0;
        reset = 1'b1;
        last = '0;
        exp_err_vis = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1;

        chk("rst_height", 192'(runner_height), 192'(0));
        chk("rst_count",  192'(frame_count),   192'(0));
        chk("rst_map",    192'(obst_map),      192'(0));
        chk("rst_flags",  192'({runner_valid, collision, frame_done, proto_err}), 192'(0));
        idle(100);

        // Runner at offset 5, pair 3 at height 2
        px(0, BY, BG);
        px(0, BY - 5, RUN);
        px(8, BY - 2, OBS);
        px(0, BY, BG);
        chk("tp_frame_done", 192'(frame_done),    192'(1));
        chk("tp_height",     192'(runner_height), 192'(5));
        chk("tp_valid",      192'(runner_valid),  192'(1));
        chk("tp_pair3",      192'(obst_map[7:6]), 192'(2));
        chk("tp_count",      192'(frame_count),   192'(1));

        // Collision: runner at offset 2 vs pair 0 height 3, then offset 4
        px(0, BY - 2, RUN);
        px(2, BY - 3, OBS);
        px(0, BY, BG);
        chk("coll_hit", 192'(collision), 192'(1));
        px(0, BY - 4, RUN);
        px(3, BY - 3, OBS);
        px(0, BY, BG);
        chk("coll_miss", 192'(collision), 192'(0));
        px(5, BY, BG);

        for (int f = 0; f < 120; f++) rand_frame(0);

        // Out-of-range runner pixel below baseline
        px(0, BY, BG);
        px(0, 90, BG);
        chk("err_set", 192'(proto_err), 192'(1));
        px(0, BY - 7, RUN);
        px(6, BY - 1, OBS);
        px(0, BY, BG);
        chk("err_sticky", 192'(proto_err), 192'(1));

        // Reset mid-frame, then resync
        px(0, BY - 3, RUN);
        px(10, BY - 2, OBS);
        do_reset();
        px(5, BY - 1, OBS);
        px(0, BY - 1, RUN);
        px(0, BY, BG);
        px(0, BY - 3, RUN);
        px(4, BY - 2, OBS);
        px(0, BY, BG);
        chk("resync_count", 192'(frame_count), 192'(1));
        chk("resync_err",   192'(proto_err),   192'(0));

        // Frame counter wrap
        px(2, BY, BG);
        idle(1);
        force dut.r_frame_count = 16'hFFFE;
        m_count = 16'hFFFE;
        last.count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.r_frame_count;
        idle(1);
        px(0, BY, BG);
        chk("wrap_ffff", 192'(frame_count), 192'(16'hFFFF));
        px(2, BY, BG);
        px(0, BY, BG);
        chk("wrap_zero", 192'(frame_count), 192'(0));
        px(2, BY, BG);

        for (int f = 0; f < 60; f++) rand_frame(1);
        px(0, BY, BG);
        idle(4);

        mon_en = 0;
        chk("queue_drain", 192'(q.size()), 192'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
